// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: pipelined WIDTH-bit adder, one BLOCK-bit carry-lookahead
// slice per stage, valid/ready handshake on both sides with bubble collapse.
// Optional build macro CLA_PIPE_FLAGS_EN adds registered Ovf/Zero/Neg outputs.
// WIDTH must be a multiple of BLOCK and give at least two stages.
module cla_pipe_adder #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout
`ifdef CLA_PIPE_FLAGS_EN
  ,
  output logic             Ovf,
  output logic             Zero,
  output logic             Neg
`endif
);

  localparam int N = WIDTH / BLOCK;

  // Block carries written out as sum-of-products lookahead terms; each
  // carry is a flat AND-OR of generate/propagate bits, not a ripple chain.
  function automatic logic [BLOCK:0] lookahead(input logic [BLOCK-1:0] g,
                                               input logic [BLOCK-1:0] p,
                                               input logic c0);
    logic [BLOCK:0] c;
    logic           term;
    c    = '0;
    c[0] = c0;
    for (int i = 0; i < BLOCK; i++) begin
      term = c0;
      for (int m = 0; m <= i; m++) term = term & p[m];
      c[i+1] = term;
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int m = j + 1; m <= i; m++) term = term & p[m];
        c[i+1] = c[i+1] | term;
      end
    end
    return c;
  endfunction

  logic [N-1:0]     valid_reg;
  logic [N-1:0]     valid_in;
  logic [N-1:0]     load;
  logic [N-1:0]     carry_reg;
  logic [N-1:0]     carry_in;
  logic [N-1:0]     carry_next;
  // acc holds the not-yet-added A blocks in its low part and the finished
  // sum blocks in its high part; after the last stage it is the full sum.
  logic [WIDTH-1:0] acc_reg  [N];
  logic [WIDTH-1:0] acc_next [N];
  // Pending B blocks, shifted down so the next block is always at the bottom.
  logic [WIDTH-1:0] opb_reg  [N-1];
  logic [WIDTH-1:0] opb_next [N-1];

  // Load chain: a stage advances when it is empty or its successor advances.
  always_comb begin
    load      = '0;
    load[N-1] = !valid_reg[N-1] || out_ready;
    for (int k = N - 2; k >= 0; k--) load[k] = !valid_reg[k] || load[k+1];
  end

  assign in_ready = reset && load[0];
  assign valid_in = {valid_reg[N-2:0], in_valid};
  assign carry_in = {carry_reg[N-2:0], Cin};

  for (genvar gi = 0; gi < N; gi++) begin : g_stage
    logic [BLOCK-1:0]       a_blk;
    logic [BLOCK-1:0]       b_blk;
    logic [BLOCK-1:0]       g_blk;
    logic [BLOCK-1:0]       p_blk;
    logic [BLOCK-1:0]       s_blk;
    logic [BLOCK:0]         c_blk;
    logic [WIDTH-BLOCK-1:0] a_high;

    if (gi == 0) begin : g_first
      assign a_blk  = A[BLOCK-1:0];
      assign b_blk  = B[BLOCK-1:0];
      assign a_high = A[WIDTH-1:BLOCK];
    end else begin : g_later
      assign a_blk  = acc_reg[gi-1][BLOCK-1:0];
      assign b_blk  = opb_reg[gi-1][BLOCK-1:0];
      assign a_high = acc_reg[gi-1][WIDTH-1:BLOCK];
    end

    assign g_blk          = a_blk & b_blk;
    assign p_blk          = a_blk | b_blk;
    assign c_blk          = lookahead(g_blk, p_blk, carry_in[gi]);
    assign s_blk          = a_blk ^ b_blk ^ c_blk[BLOCK-1:0];
    assign acc_next[gi]   = {s_blk, a_high};
    assign carry_next[gi] = c_blk[BLOCK];

    if (gi < N - 1) begin : g_pass_b
      if (gi == 0) begin : g_from_port
        assign opb_next[gi] = {{BLOCK{1'b0}}, B[WIDTH-1:BLOCK]};
      end else begin : g_from_reg
        assign opb_next[gi] = {{BLOCK{1'b0}}, opb_reg[gi-1][WIDTH-1:BLOCK]};
      end
    end
  end

  // Stage registers: valid follows the load chain; data only moves with a
  // valid transaction so idle stages keep their last contents.
  always_ff @(posedge clock) begin
    if (!reset) begin
      valid_reg <= '0;
      carry_reg <= '0;
      for (int k = 0; k < N; k++) acc_reg[k] <= '0;
      for (int k = 0; k < N - 1; k++) opb_reg[k] <= '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (load[k]) valid_reg[k] <= valid_in[k];
        if (load[k] && valid_in[k]) begin
          carry_reg[k] <= carry_next[k];
          acc_reg[k]   <= acc_next[k];
        end
      end
      for (int k = 0; k < N - 1; k++) begin
        if (load[k] && valid_in[k]) opb_reg[k] <= opb_next[k];
      end
    end
  end

  assign out_valid = valid_reg[N-1];
  assign S         = acc_reg[N-1];
  assign Cout      = carry_reg[N-1];

`ifdef CLA_PIPE_FLAGS_EN
  logic [N-2:0] sign_a_reg;
  logic [N-2:0] sign_b_reg;
  logic [N-1:0] sign_a_in;
  logic [N-1:0] sign_b_in;
  logic         ovf_reg;
  logic         zero_reg;
  logic         neg_reg;
  logic         ovf_next;
  logic         zero_next;
  logic         neg_next;

  assign sign_a_in = {sign_a_reg, A[WIDTH-1]};
  assign sign_b_in = {sign_b_reg, B[WIDTH-1]};

  // Flags are judged on the completed sum as it enters the last stage.
  always_comb begin
    ovf_next  = (sign_a_in[N-1] == sign_b_in[N-1]) &&
                (acc_next[N-1][WIDTH-1] != sign_a_in[N-1]);
    zero_next = (acc_next[N-1] == '0);
    neg_next  = acc_next[N-1][WIDTH-1];
  end

  // Operand sign bits travel with the data; flags load with the last stage.
  always_ff @(posedge clock) begin
    if (!reset) begin
      sign_a_reg <= '0;
      sign_b_reg <= '0;
      ovf_reg    <= 1'b0;
      zero_reg   <= 1'b0;
      neg_reg    <= 1'b0;
    end else begin
      for (int k = 0; k < N - 1; k++) begin
        if (load[k] && valid_in[k]) begin
          sign_a_reg[k] <= sign_a_in[k];
          sign_b_reg[k] <= sign_b_in[k];
        end
      end
      if (load[N-1] && valid_in[N-1]) begin
        ovf_reg  <= ovf_next;
        zero_reg <= zero_next;
        neg_reg  <= neg_next;
      end
    end
  end

  assign Ovf  = ovf_reg;
  assign Zero = zero_reg;
  assign Neg  = neg_reg;
`endif

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Self-checking bench for cla_pipe_adder: directed cases plus a randomized
// stream checked against an arithmetic reference model and a result queue.
module tb_cla_pipe_adder;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a_d = '0;
  logic [W-1:0] b_d = '0;
  logic         cin_d = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] s;
  logic         cout;
`ifdef CLA_PIPE_FLAGS_EN
  logic         ovf;
  logic         zero;
  logic         neg;
`endif

  int          total = 0;
  int          bad = 0;
  logic [35:0] exp_q[$];

  always #5 clk = ~clk;

  cla_pipe_adder #(.WIDTH(W), .BLOCK(8)) dut (
    .clock    (clk),
    .reset    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (a_d),
    .B        (b_d),
    .Cin      (cin_d),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .S        (s),
    .Cout     (cout)
`ifdef CLA_PIPE_FLAGS_EN
    ,
    .Ovf      (ovf),
    .Zero     (zero),
    .Neg      (neg)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: plain wide addition; flags from the operand and sum signs.
  function automatic logic [35:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic c);
    logic [W:0]  r;
    logic [35:0] e;
    r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    e = {3'b000, r};
`ifdef CLA_PIPE_FLAGS_EN
    e[35] = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
    e[34] = (r[W-1:0] == '0);
    e[33] = r[W-1];
`endif
    return e;
  endfunction

  function automatic logic [35:0] observed();
`ifdef CLA_PIPE_FLAGS_EN
    return {ovf, zero, neg, cout, s};
`else
    return {3'b000, cout, s};
`endif
  endfunction

  // One clock of scoreboarded traffic; called at a negedge with inputs driven.
  task automatic tick(output bit acc);
    #1;
    acc = in_valid && in_ready;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("spurious_out", 64'(out_valid), 64'd0);
      else chk("stream", 64'(observed()), 64'(exp_q.pop_front()));
    end
    if (acc) exp_q.push_back(model(a_d, b_d, cin_d));
    @(negedge clk);
  endtask

  // Single isolated add: checks latency edge by edge and no duplicate output.
  task automatic single(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input logic [W-1:0] es, input logic ec);
    a_d = a; b_d = b; cin_d = c; in_valid = 1'b1; out_ready = 1'b1;
    #1 chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk({tag, "_lat_e0"}, 64'(out_valid), 64'd0);
    @(negedge clk);
    #1 chk({tag, "_lat_e1"}, 64'(out_valid), 64'd0);
    @(negedge clk);
    #1 chk({tag, "_lat_e2"}, 64'(out_valid), 64'd0);
    @(negedge clk);
    #1;
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_s"}, 64'(s), 64'(es));
    chk({tag, "_cout"}, 64'(cout), 64'(ec));
    @(negedge clk);
    #1 chk({tag, "_no_dup"}, 64'(out_valid), 64'd0);
    @(negedge clk);
  endtask

`ifdef CLA_PIPE_FLAGS_EN
  task automatic flag_case(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] es, input logic eo, input logic ez, input logic en);
    a_d = a; b_d = b; cin_d = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_s"}, 64'(s), 64'(es));
    chk({tag, "_ovf"}, 64'(ovf), 64'(eo));
    chk({tag, "_zero"}, 64'(zero), 64'(ez));
    chk({tag, "_neg"}, 64'(neg), 64'(en));
    @(negedge clk);
    @(negedge clk);
  endtask
`endif

  initial begin
    bit           acc;
    bit           pend;
    logic [W-1:0] bpa[6];
    logic [W-1:0] bpb[6];
    logic [35:0]  hold_exp;
    int           idx;

    // Reset and idle
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_s", 64'(s), 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
`ifdef CLA_PIPE_FLAGS_EN
    chk("rst_flags", 64'({ovf, zero, neg}), 64'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("rel_in_ready", 64'(in_ready), 64'd1);
    chk("rel_out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);

    // Full carry chain through every slice
    single("carry_cin0", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1);
    single("carry_cin1", 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 32'h0000_0001, 1'b1);

    // Back-to-back: results on consecutive cycles
    out_ready = 1'b1;
    a_d = 32'h1234_5678; b_d = 32'h8765_4321; cin_d = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    a_d = 32'h8000_0000; b_d = 32'h8000_0000; cin_d = 1'b0;
    #1 chk("b2b_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("b2b_first_valid", 64'(out_valid), 64'd1);
    chk("b2b_first", 64'({cout, s}), 64'({1'b0, 32'h9999_999A}));
    @(negedge clk);
    #1;
    chk("b2b_second_valid", 64'(out_valid), 64'd1);
    chk("b2b_second", 64'({cout, s}), 64'({1'b1, 32'h0000_0000}));
    @(negedge clk);
    #1 chk("b2b_idle", 64'(out_valid), 64'd0);
    @(negedge clk);

`ifdef CLA_PIPE_FLAGS_EN
    flag_case("flags_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1, 1'b0, 1'b1);
    flag_case("flags_zero", 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1, 1'b0);
`endif

    // Backpressure: 5 offers with out_ready low, only 4 fit
    for (int i = 0; i < 6; i++) begin
      bpa[i] = $urandom;
      bpb[i] = $urandom;
    end
    out_ready = 1'b0;
    idx = 0;
    for (int i = 0; i < 6; i++) begin
      a_d = bpa[idx]; b_d = bpb[idx]; cin_d = idx[0]; in_valid = 1'b1;
      tick(acc);
      chk("bp_accept", 64'(acc), 64'(i < 4));
      if (acc) idx++;
    end
    hold_exp = model(bpa[0], bpb[0], 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_hold_valid", 64'(out_valid), 64'd1);
      chk("bp_hold_s", 64'({cout, s}), 64'(hold_exp[W:0]));
      chk("bp_hold_in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick(acc);
      if (acc) in_valid = 1'b0;
    end
    chk("bp_drain_left", 64'(exp_q.size()), 64'd0);
    chk("bp_drain_idle", 64'(out_valid), 64'd0);

    // Randomized stream with random stalls
    pend = 1'b0;
    for (int i = 0; i < 120; i++) begin
      if (!pend && ($urandom_range(0, 3) != 0)) begin
        a_d = $urandom; b_d = $urandom; cin_d = 1'($urandom_range(0, 1));
        in_valid = 1'b1;
        pend = 1'b1;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      tick(acc);
      if (acc) begin
        pend = 1'b0;
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick(acc);
    chk("rand_drain_left", 64'(exp_q.size()), 64'd0);

    // Reset with two results in flight
    out_ready = 1'b1;
    a_d = $urandom; b_d = $urandom; cin_d = 1'b0; in_valid = 1'b1;
    tick(acc);
    chk("mid_accept0", 64'(acc), 64'd1);
    a_d = $urandom; b_d = $urandom; cin_d = 1'b1;
    tick(acc);
    chk("mid_accept1", 64'(acc), 64'd1);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_s", 64'({cout, s}), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
    exp_q.delete();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1 chk("mid_no_stale", 64'(out_valid), 64'd0);
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cla_pipe_adder.md
Name: cla_pipe_adder

Overview:
- Pipelined WIDTH-bit adder built from BLOCK-bit carry-lookahead slices, with one slice per pipeline stage.
- The carry and the unused upper operand bytes are registered between stages, so the adder runs at the clock rate of a single slice.
- Sits downstream of the ALU operand muxes and feeds the multdiv/ALU result path.
- Uses a valid/ready handshake on both sides, and bubbles collapse as data moves forward.

Parameters:
- WIDTH, 32, operand/sum width; must be a multiple of BLOCK.
- BLOCK, 8, slice width; stage count N = WIDTH/BLOCK (4 by default).

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset; sampled on clock rising edge
- in_valid  in  1  operands on A/B/Cin are valid
- in_ready  out  1  stage 0 can accept this cycle
- A  in  WIDTH  operand A
- B  in  WIDTH  operand B
- Cin  in  1  carry into bit 0
- out_valid  out  1  S/Cout hold a completed result
- out_ready  in  1  consumer accepts the result this cycle
- S  out  WIDTH  sum
- Cout  out  1  carry out of the MSB

Behaviour:
- Slice function, block k:
  - Gs = A&B, Ps = A|B.
  - c[0] = carry-in; c[i+1] = Gs[i] | Ps[i]&c[i], expanded as lookahead (no ripple chain).
  - S[i] = A[i]^B[i]^c[i].
  - Block carry-out feeds the next stage.
- Stage registers R0..R(N-1). Each holds a valid bit, the completed low sum bytes, the pending high bytes of A and B, and the running carry.
- Stage 0 computes block 0 combinationally from the input ports. Stage k computes block k from R(k-1).
- Advance rules:
  - R(N-1) loads when !valid(N-1) | out_ready.
  - R(k) loads when !valid(k) | R(k+1) loads.
  - in_ready = stage-0 load condition.
- Transfers:
  - Input transfer: in_valid & in_ready.
  - Output transfer: out_valid & out_ready.
  - A stage that loads with no valid predecessor clears its valid bit (bubble).
- Latency:
  - Operands accepted at edge e appear on S/Cout with out_valid=1 after edge e+N-1 (edge e+3 for N=4), given no stall.
  - Throughput is 1 result per clock when out_ready is held high.
- Outputs:
  - S = R(N-1) sum; Cout = R(N-1) carry.
  - S/Cout are stable while out_valid=1 and out_ready=0.
- Stall: while out_ready=0, full stages hold their contents. Empty stages upstream of a stall still fill (bubble collapse). in_ready drops only when R0 is full and cannot advance.
- Wrap-around: the sum is modulo 2^WIDTH; Cout carries the overflow bit.
- in_valid while in_ready=0: no transfer. The producer must hold its operands.
- Reset:
  - When reset=0 at a clock edge, all valid bits and all data registers are cleared to 0.
  - Outputs after that edge: out_valid=0, S=0, Cout=0.
  - While reset=0, in_ready=0. in_ready returns to 1 in the first cycle after release.
  - An in-flight result is discarded when reset asserts mid-operation.
- Simultaneous output transfer and input transfer in a full pipeline: every stage shifts, with no loss and no duplication.

Optional Feature:
- Macro: CLA_PIPE_FLAGS_EN.
- Defined: adds outputs Ovf, Zero and Neg (1 bit each), registered alongside R(N-1) and valid with out_valid.
  - Ovf = (A[MSB]==B[MSB]) & (S[MSB]!=A[MSB]).
  - Zero = (S==0).
  - Neg = S[MSB].
  - Each high-byte stage also carries the operand sign bits.
  - All three flags reset to 0.
- Undefined: the ports and their registers do not exist; all other behaviour is identical.

Test Plan:
- Reset and idle: reset=0 for 2 edges, then release. Required: out_valid=0, S=0, Cout=0; in_ready=0 during reset and 1 in the cycle after release.
- Single add, full carry chain: A=FFFFFFFF, B=00000001, Cin=0. Required: after edge e+3, S=00000000, Cout=1, out_valid=1; with Cin=1 the result is S=00000001, Cout=1.
- Back-to-back stream, out_ready=1: accept 12345678+87654321 Cin=1 (expect 9999999A, Cout 0), then 80000000+80000000 Cin=0 (expect 00000000, Cout 1) on the next cycle. Required: results on consecutive cycles, one per clock.
- Backpressure: fill with 5 transactions while out_ready=0. Required: in_ready falls after 4 accepts; S is held stable; raising out_ready drains in order with no loss or duplication.
- Reset mid-stream: assert reset=0 while 2 results are in flight. Required: both are discarded and out_valid=0 next cycle; no stale result appears after release.
- Flags (with CLA_PIPE_FLAGS_EN): 7FFFFFFF+00000001 Cin=0. Required: S=80000000, Ovf=1, Neg=1, Zero=0; FFFFFFFF+00000001 gives Zero=1, Ovf=0.
